writeback_stage_reg: RTL and testbench
======================================

Name: writeback_stage_reg

Overview:
Parametrised next-generation writeback stage for the pipelined core. It absorbs the MEM/WB pipeline register with stall/flush control and selects the result from one of four sources. It also performs load-data alignment with sign/zero extension and drives the register-file write port, with writes to register 0 suppressed. An optional retired-instruction counter supports performance measurement.

Parameters:
AWL, 6, address width; the register-file index is AWL-1 bits (32 registers by default)
DWL, 32, datapath width in bits; must be a multiple of 8 and at least 32
CNTW, 32, width of the retired-instruction counter

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
STALLW  in  1  hold W register contents this cycle
FLUSHW  in  1  load a bubble into W register this cycle
ValidM  in  1  instruction in M stage is valid
RFWEM  in  1  register-file write enable from M
ResSelM  in  2  result select: 00 ALU, 01 data memory, 10 PC+4, 11 immediate
LdSizeM  in  2  load size: 00 byte, 01 half, 10 word, 11 treated as word
LdSignedM  in  1  1 = sign-extend load, 0 = zero-extend
ByteOffM  in  2  byte offset of load address (address bits 1:0)
RFAM  in  AWL-1  destination register index from M
DMOutM, ALUOutM, PCPlus4M, ImmM  in  DWL each  candidate result values
ValidW  out  1  W register holds a valid instruction
RFWEW  out  1  register-file write enable
RFAW  out  AWL-1  register-file write address
ResultW  out  DWL  write-back data; also the forwarding value for the hazard unit
RetireCnt  out  CNTW  number of retired instructions

Behaviour:
- Reset: RST high asynchronously clears every register. ValidW=0, RFWEW=0, RFAW=0, ResultW=0, RetireCnt=0. Reset asserted mid-operation discards the held instruction immediately, without waiting for a clock edge.
- Register update on a rising edge, in priority order:
  - FLUSHW=1: load a bubble; all fields are zeroed, including valid and write enable.
  - Otherwise STALLW=1: hold all fields.
  - Otherwise: capture all M-stage inputs.
  - FLUSHW and STALLW asserted together: flush wins.
- Latency: exactly 1 cycle from M inputs to W outputs. ResultW and RFWEW are combinational from the registered fields only; there is no path from M inputs to W outputs.
- RFWEW = registered write enable AND ValidW AND (RFAW != 0).
- ResultW equals the registered RFAW-independent result regardless of write-enable state.
- Load extraction, applied only when ResSel=01:
  - Byte: select byte ByteOff, i.e. bits [8*ByteOff+7 : 8*ByteOff].
  - Half: select halfword ByteOff[1]; ByteOff[0] is ignored (misaligned halves are not trapped here).
  - Word or size 11: pass the low 32 bits; ByteOff is ignored.
  - The extracted value is extended to DWL. The sign bit is the top bit of the selected field when LdSigned=1; otherwise upper bits are 0.
  - When DWL > 32, the word case also extends from bit 31.
- ResSel values 00, 10 and 11 pass ALUOut, PCPlus4 and Imm unmodified.
- Retire counter:
  - Increments by 1 on each rising edge where ValidW=1 and STALLW=0 and FLUSHW=0.
  - Counts instructions leaving W; bubbles and stalled cycles do not count.
  - Wraps from 2^CNTW-1 to 0 with no saturation.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined: the retire counter is implemented as described above.
- Undefined: no counter register is synthesised; RetireCnt is tied to 0; all other behaviour is identical.

Test Plan:
- Reset and capture: RST pulse, then M inputs ValidM=1, RFWEM=1, RFAM=5, ResSelM=00, ALUOutM=0x0000_1234 -> one edge later ValidW=1, RFWEW=1, RFAW=5, ResultW=0x0000_1234.
- Loads: DMOutM=0x8899_AABB, ResSelM=01 ->
  - byte, ByteOff=2, signed: ResultW=0xFFFF_FF99.
  - same, unsigned: ResultW=0x0000_0099.
  - half, ByteOff=2, signed: ResultW=0xFFFF_8899.
  - half, ByteOff=1, unsigned: ResultW=0x0000_AABB.
  - word: ResultW=0x8899_AABB.
- x0 suppression: RFAM=0, RFWEM=1, ValidM=1, ResSelM=11, ImmM=7 -> RFWEW=0, ResultW=7.
- Stall/flush priority: hold STALLW=1 for 3 cycles while M inputs change -> W outputs unchanged. Assert STALLW=1 and FLUSHW=1 together -> next edge ValidW=0, RFWEW=0, ResultW=0.
- Async reset mid-stream: RST asserted between clock edges while ValidW=1 -> ValidW, RFWEW and RetireCnt go to 0 before the next edge.
- Counter (WB_RETIRE_CNT_EN defined, CNTW=4):
  - 17 valid unstalled instructions -> RetireCnt=1, because it wraps at 16.
  - Interleaved bubbles and stalls do not increment the count.
  - With the macro undefined, RetireCnt stays at 0 throughout.

Source files
------------

// File: rtl/writeback_stage_reg_if.sv
// M-to-W pipeline boundary bundle for the writeback stage: pipeline control,
// M-stage candidates in, register-file write port and retire count out.
interface writeback_stage_reg_if #(
  parameter int AWL  = 6,
  parameter int DWL  = 32,
  parameter int CNTW = 32
);
  logic             STALLW;
  logic             FLUSHW;
  logic             ValidM;
  logic             RFWEM;
  logic [1:0]       ResSelM;
  logic [1:0]       LdSizeM;
  logic             LdSignedM;
  logic [1:0]       ByteOffM;
  logic [AWL-2:0]   RFAM;
  logic [DWL-1:0]   DMOutM;
  logic [DWL-1:0]   ALUOutM;
  logic [DWL-1:0]   PCPlus4M;
  logic [DWL-1:0]   ImmM;
  logic             ValidW;
  logic             RFWEW;
  logic [AWL-2:0]   RFAW;
  logic [DWL-1:0]   ResultW;
  logic [CNTW-1:0]  RetireCnt;

  modport master (
    output STALLW, FLUSHW, ValidM, RFWEM, ResSelM, LdSizeM, LdSignedM,
           ByteOffM, RFAM, DMOutM, ALUOutM, PCPlus4M, ImmM,
    input  ValidW, RFWEW, RFAW, ResultW, RetireCnt
  );

  modport slave (
    input  STALLW, FLUSHW, ValidM, RFWEM, ResSelM, LdSizeM, LdSignedM,
           ByteOffM, RFAM, DMOutM, ALUOutM, PCPlus4M, ImmM,
    output ValidW, RFWEW, RFAW, ResultW, RetireCnt
  );
endinterface

// File: rtl/writeback_stage_reg.sv
// MEM/WB register with stall/flush, result select, load align/extend and x0 suppression.
// Optional retired-instruction counter enabled by WB_RETIRE_CNT_EN.
module writeback_stage_reg #(
  parameter int AWL  = 6,
  parameter int DWL  = 32,
  parameter int CNTW = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  writeback_stage_reg_if.slave   bus
);
  localparam int RW = AWL - 1;

  typedef struct packed {
    logic           valid;
    logic           rfwe;
    logic [RW-1:0]  rfa;
    logic [1:0]     ressel;
    logic [1:0]     ldsize;
    logic           ldsigned;
    logic [1:0]     byteoff;
    logic [DWL-1:0] dmout;
    logic [DWL-1:0] aluout;
    logic [DWL-1:0] pcplus4;
    logic [DWL-1:0] imm;
  } wb_reg_t;

  wb_reg_t m_d, w_q;

  always_comb begin
    m_d          = '0;
    m_d.valid    = bus.ValidM;
    m_d.rfwe     = bus.RFWEM;
    m_d.rfa      = bus.RFAM;
    m_d.ressel   = bus.ResSelM;
    m_d.ldsize   = bus.LdSizeM;
    m_d.ldsigned = bus.LdSignedM;
    m_d.byteoff  = bus.ByteOffM;
    m_d.dmout    = bus.DMOutM;
    m_d.aluout   = bus.ALUOutM;
    m_d.pcplus4  = bus.PCPlus4M;
    m_d.imm      = bus.ImmM;
  end

  // Flush outranks stall so a squashed instruction never lingers in W.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             w_q <= '0;
    else if (bus.FLUSHW) w_q <= '0;
    else if (!bus.STALLW) w_q <= m_d;
  end

  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_field;
  logic [31:0]    ld_mask;
  logic           ld_msb;
  logic [DWL-1:0] mask_ext;
  logic [DWL-1:0] load_val;
  logic [DWL-1:0] result;

  always_comb begin
    ld_byte = '0;
    case (w_q.byteoff)
      2'd0: ld_byte = w_q.dmout[7:0];
      2'd1: ld_byte = w_q.dmout[15:8];
      2'd2: ld_byte = w_q.dmout[23:16];
      2'd3: ld_byte = w_q.dmout[31:24];
      default: ld_byte = '0;
    endcase
    // Halfword uses only the upper offset bit; misalignment is not trapped here.
    ld_half = w_q.byteoff[1] ? w_q.dmout[31:16] : w_q.dmout[15:0];

    case (w_q.ldsize)
      2'b00: begin
        ld_field = {24'b0, ld_byte};
        ld_mask  = 32'h0000_00ff;
        ld_msb   = ld_byte[7];
      end
      2'b01: begin
        ld_field = {16'b0, ld_half};
        ld_mask  = 32'h0000_ffff;
        ld_msb   = ld_half[15];
      end
      default: begin
        ld_field = w_q.dmout[31:0];
        ld_mask  = 32'hffff_ffff;
        ld_msb   = w_q.dmout[31];
      end
    endcase

    // Fill everything above the selected field with its sign bit when signed.
    mask_ext       = '0;
    mask_ext[31:0] = ld_mask;
    load_val       = '0;
    load_val[31:0] = ld_field;
    if (w_q.ldsigned && ld_msb) load_val = load_val | ~mask_ext;
  end

  always_comb begin
    result = '0;
    case (w_q.ressel)
      2'b00:   result = w_q.aluout;
      2'b01:   result = load_val;
      2'b10:   result = w_q.pcplus4;
      2'b11:   result = w_q.imm;
      default: result = '0;
    endcase
  end

  assign bus.ValidW  = w_q.valid;
  assign bus.RFAW    = w_q.rfa;
  assign bus.ResultW = result;
  assign bus.RFWEW   = w_q.rfwe & w_q.valid & (w_q.rfa != '0);

`ifdef WB_RETIRE_CNT_EN
  logic [CNTW-1:0] retire_cnt;

  // An instruction retires when it leaves W: valid and neither held nor squashed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) retire_cnt <= '0;
    else if (w_q.valid && !bus.STALLW && !bus.FLUSHW) retire_cnt <= retire_cnt + 1'b1;
  end

  assign bus.RetireCnt = retire_cnt;
`else
  assign bus.RetireCnt = '0;
`endif
endmodule

// File: tb/tb_writeback_stage_reg.sv
// Randomized bench for writeback_stage_reg against a behavioural W-stage model,
// plus directed load, x0, stall/flush, async-reset and counter-wrap cases.
module tb_writeback_stage_reg;
  localparam int AWL  = 6;
  localparam int DWL  = 32;
  localparam int CNTW = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  writeback_stage_reg_if #(.AWL(AWL), .DWL(DWL), .CNTW(CNTW)) bus ();

  writeback_stage_reg #(.AWL(AWL), .DWL(DWL), .CNTW(CNTW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // reference W-stage state
  logic        m_valid, m_we;
  logic [4:0]  m_rfa;
  logic [31:0] m_res;
  int unsigned m_cnt;

  // directed load table: size, signed, offset, expected ResultW for DMOut=0x8899AABB
  logic [1:0]  ld_sz [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  logic        ld_sg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0]  ld_of [5] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd3};
  logic [31:0] ld_ex [5] = '{32'hFFFF_FF99, 32'h0000_0099, 32'hFFFF_8899,
                             32'h0000_AABB, 32'h8899_AABB};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [1:0] size,
      input logic sgn, input logic [1:0] off, input logic [31:0] dm, input logic [31:0] alu,
      input logic [31:0] pc, input logic [31:0] imm);
    logic [63:0] v;
    logic [63:0] lim;
    int bits, shift;
    case (sel)
      2'd0: return alu;
      2'd2: return pc;
      2'd3: return imm;
      default: begin
        if (size == 2'd0)      begin bits = 8;  shift = 8 * int'(off); end
        else if (size == 2'd1) begin bits = 16; shift = (off >= 2'd2) ? 16 : 0; end
        else                   begin bits = 32; shift = 0; end
        lim = 64'd1 << bits;
        v = (64'(dm) >> shift) % lim;
        if (sgn && v >= lim / 2) v = v + (64'd1 << 32) - lim;
        return v[31:0];
      end
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_rfa = 0; m_res = 0; m_cnt = 0;
  endtask

  task automatic check_all();
    chk("valid", 64'(bus.ValidW), 64'(m_valid));
    chk("rfwe", 64'(bus.RFWEW), 64'(m_we && m_valid && m_rfa != 0));
    chk("rfa", 64'(bus.RFAW), 64'(m_rfa));
    chk("result", 64'(bus.ResultW), 64'(m_res));
`ifdef WB_RETIRE_CNT_EN
    chk("retire", 64'(bus.RetireCnt), 64'(m_cnt));
`else
    chk("retire", 64'(bus.RetireCnt), 64'd0);
`endif
  endtask

  // one rising edge: model follows the same inputs, outputs checked on the falling edge
  task automatic cycle();
    @(posedge CLK);
    if (RST) model_reset();
    else begin
      if (m_valid && !bus.STALLW && !bus.FLUSHW) m_cnt = (m_cnt + 1) % (1 << CNTW);
      if (bus.FLUSHW) begin
        m_valid = 0; m_we = 0; m_rfa = 0; m_res = 0;
      end else if (!bus.STALLW) begin
        m_valid = bus.ValidM;
        m_we    = bus.RFWEM;
        m_rfa   = bus.RFAM;
        m_res   = ref_result(bus.ResSelM, bus.LdSizeM, bus.LdSignedM, bus.ByteOffM,
                             bus.DMOutM, bus.ALUOutM, bus.PCPlus4M, bus.ImmM);
      end
    end
    @(negedge CLK);
    check_all();
  endtask

  task automatic set_m(input logic v, input logic we, input logic [4:0] a, input logic [1:0] sel,
      input logic [1:0] sz, input logic sg, input logic [1:0] off, input logic [31:0] dm,
      input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm);
    bus.ValidM = v; bus.RFWEM = we; bus.RFAM = a; bus.ResSelM = sel;
    bus.LdSizeM = sz; bus.LdSignedM = sg; bus.ByteOffM = off;
    bus.DMOutM = dm; bus.ALUOutM = alu; bus.PCPlus4M = pc; bus.ImmM = imm;
  endtask

  task automatic rand_m();
    set_m(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 2'($urandom),
          1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom);
  endtask

  initial begin
    RST = 1'b1;
    bus.STALLW = 0; bus.FLUSHW = 0;
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge CLK);
    check_all();
    RST = 1'b0;

    // capture
    set_m(1, 1, 5'd5, 2'd0, 0, 0, 0, 0, 32'h0000_1234, 0, 0);
    cycle();
    chk("cap_res", 64'(bus.ResultW), 64'h1234);
    chk("cap_we", 64'(bus.RFWEW), 64'd1);
    chk("cap_rfa", 64'(bus.RFAW), 64'd5);

    // loads
    for (int i = 0; i < 5; i++) begin
      set_m(1, 1, 5'd9, 2'd1, ld_sz[i], ld_sg[i], ld_of[i], 32'h8899_AABB, 0, 0, 0);
      cycle();
      chk("load", 64'(bus.ResultW), 64'(ld_ex[i]));
    end

    // x0 suppression
    set_m(1, 1, 5'd0, 2'd3, 0, 0, 0, 0, 0, 0, 32'd7);
    cycle();
    chk("x0_we", 64'(bus.RFWEW), 64'd0);
    chk("x0_res", 64'(bus.ResultW), 64'd7);

    // stall holds for 3 cycles while M changes, then stall+flush bubbles
    set_m(1, 1, 5'd12, 2'd2, 0, 0, 0, 0, 0, 32'hCAFE_0004, 0);
    cycle();
    bus.STALLW = 1;
    for (int i = 0; i < 3; i++) begin
      rand_m();
      cycle();
      chk("stall_res", 64'(bus.ResultW), 64'hCAFE_0004);
    end
    bus.FLUSHW = 1;
    cycle();
    chk("sf_valid", 64'(bus.ValidW), 64'd0);
    chk("sf_res", 64'(bus.ResultW), 64'd0);
    bus.STALLW = 0; bus.FLUSHW = 0;

    // async reset between edges
    set_m(1, 1, 5'd3, 2'd0, 0, 0, 0, 0, 32'h55, 0, 0);
    cycle();
    cycle();
    #2 RST = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.ValidW), 64'd0);
    chk("arst_we", 64'(bus.RFWEW), 64'd0);
    chk("arst_cnt", 64'(bus.RetireCnt), 64'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;

    // 17 retirements wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      rand_m();
      bus.ValidM = 1;
      cycle();
    end
    bus.ValidM = 0;
    cycle();
`ifdef WB_RETIRE_CNT_EN
    chk("wrap", 64'(bus.RetireCnt), 64'd1);
`else
    chk("wrap", 64'(bus.RetireCnt), 64'd0);
`endif

    // random traffic with interleaved stalls, flushes and bubbles
    for (int i = 0; i < 400; i++) begin
      rand_m();
      bus.STALLW = ($urandom_range(0, 3) == 0);
      bus.FLUSHW = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
